// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the PC sequencer and its return-address stack.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      SEL_INC  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_JMP  = 3'd2,
      SEL_CALL = 3'd3,
      SEL_RET  = 3'd4
   } sel_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH x AW LIFO with occupancy flags and
// single-cycle overflow/underflow pulses for rejected push/pop.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] top,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          udf
);

   localparam int IW = clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [AW-1:0] mem [DEPTH];
   logic [CW-1:0] count;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] top_idx;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign ovf     = push & full;
   assign udf     = pop & empty;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign wr_idx  = count[IW-1:0];
   // Top is entry[count-1]; when empty the index wraps and the value is unused.
   assign top_idx = IW'(count - CW'(1));
   assign top     = mem[top_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (do_push) begin
         count <= count + CW'(1);
      end else if (do_pop) begin
         count <= count - CW'(1);
      end
   end

   // Storage is don't-care after reset, so it carries no reset term.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= din;
   end

endmodule

// File: rtl/pc_seq_ras.sv
// Program-counter sequencer: stall, jump, relative branch, and call/return
// through an internal return-address stack with sticky error flag.
module pc_seq_ras
   import pc_seq_pkg::*;
#(
   parameter int            AW       = 8,
   parameter int            STEP     = 4,
   parameter logic [AW-1:0] RESET_PC = '0,
   parameter int            DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          jump,
   input  logic          branch,
   input  logic          call,
   input  logic          ret,
   input  logic [AW-1:0] target,
   input  logic [AW-1:0] offset,
   output logic [AW-1:0] pc,
   output logic          ras_full,
   output logic          ras_empty,
   output logic          ras_err
);

   localparam logic [AW-1:0] STEP_V = AW'(STEP);

   sel_e          sel;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] pc_br;
   logic [AW-1:0] pc_nxt;
   logic [AW-1:0] ras_top;
   logic          push;
   logic          pop;
   logic          ovf;
   logic          udf;

   assign pc_inc = pc + STEP_V;
   assign pc_br  = pc + offset;

   always_comb begin
      sel = SEL_INC;
      if (ret)         sel = SEL_RET;
      else if (call)   sel = SEL_CALL;
      else if (jump)   sel = SEL_JMP;
      else if (branch) sel = SEL_BR;
   end

   // Stack commands only fire when advancing, so a stall leaves it untouched.
   assign push = en & (sel == SEL_CALL);
   assign pop  = en & (sel == SEL_RET);

   always_comb begin
      pc_nxt = pc_inc;
      case (sel)
         SEL_RET:  pc_nxt = udf ? pc_inc : ras_top;
         SEL_CALL: pc_nxt = target;
         SEL_JMP:  pc_nxt = target;
         SEL_BR:   pc_nxt = pc_br;
         default:  pc_nxt = pc_inc;
      endcase
   end

   pc_ras #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (ras_top),
      .full  (ras_full),
      .empty (ras_empty),
      .ovf   (ovf),
      .udf   (udf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         ras_err <= 1'b0;
      end else if (en) begin
         pc <= pc_nxt;
         if (ovf | udf) ras_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_seq_ras.sv
// Scoreboard bench for pc_seq_ras: directed scenarios then random traffic,
// checked against a queue-based behavioural model.
module tb_pc_seq_ras;

   localparam int            AW       = 8;
   localparam int            STEP     = 4;
   localparam logic [AW-1:0] RESET_PC = 8'h10;
   localparam int            DEPTH    = 4;
   localparam int            MASK     = (1 << AW) - 1;

   typedef struct {
      int   pc;
      logic full;
      logic empty;
      logic err;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          jump;
   logic          branch;
   logic          call;
   logic          ret;
   logic [AW-1:0] target;
   logic [AW-1:0] offset;
   logic [AW-1:0] pc;
   logic          ras_full;
   logic          ras_empty;
   logic          ras_err;

   int   total;
   int   bad;
   exp_t sb[$];

   int   m_pc;
   int   m_stk[$];
   logic m_err;

   pc_seq_ras #(
      .AW       (AW),
      .STEP     (STEP),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .jump      (jump),
      .branch    (branch),
      .call      (call),
      .ret       (ret),
      .target    (target),
      .offset    (offset),
      .pc        (pc),
      .ras_full  (ras_full),
      .ras_empty (ras_empty),
      .ras_err   (ras_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic e, input logic j, input logic b,
                       input logic c, input logic rt, input int t, input int o);
      exp_t x;
      @(negedge clk);
      rst_n = r; en = e; jump = j; branch = b; call = c; ret = rt;
      target = AW'(t); offset = AW'(o);
      if (!r) begin
         m_pc = int'(RESET_PC);
         m_stk.delete();
         m_err = 1'b0;
      end else if (e) begin
         if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = (m_pc + STEP) & MASK; m_err = 1'b1; end
         end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + STEP) & MASK);
            else m_err = 1'b1;
            m_pc = t & MASK;
         end else if (j) m_pc = t & MASK;
         else if (b) m_pc = (m_pc + o) & MASK;
         else m_pc = (m_pc + STEP) & MASK;
      end
      x.pc    = m_pc;
      x.full  = (m_stk.size() == DEPTH);
      x.empty = (m_stk.size() == 0);
      x.err   = m_err;
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every edge after a queued stimulus yields one response to check.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            total++;
            if (int'(pc) != x.pc) begin
               bad++; $display("FAIL pc: got %02h want %02h at %0t", pc, x.pc[7:0], $time);
            end
            total++;
            if (ras_full !== x.full) begin
               bad++; $display("FAIL ras_full: got %b want %b at %0t", ras_full, x.full, $time);
            end
            total++;
            if (ras_empty !== x.empty) begin
               bad++; $display("FAIL ras_empty: got %b want %b at %0t", ras_empty, x.empty, $time);
            end
            total++;
            if (ras_err !== x.err) begin
               bad++; $display("FAIL ras_err: got %b want %b at %0t", ras_err, x.err, $time);
            end
         end
      end
   end

   initial begin
      total = 0; bad = 0;
      m_pc = 0; m_err = 1'b0;
      rst_n = 1'b0; en = 1'b0; jump = 1'b0; branch = 1'b0;
      call = 1'b0; ret = 1'b0; target = '0; offset = '0;

      // reset and increment
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      idle(3);
      // stall and wrap
      step(1, 1, 1, 0, 0, 0, 'hF8, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 1, 1, 0, 'h33, 4);
      idle(2);
      // branch / jump / priority
      step(1, 1, 1, 0, 0, 0, 'h20, 0);
      step(1, 1, 0, 1, 0, 0, 0, 'hF0);
      step(1, 1, 1, 0, 0, 0, 'h80, 0);
      step(1, 1, 1, 1, 0, 0, 'h40, 'h08);
      // nested call/ret
      step(1, 1, 1, 0, 0, 0, 'h00, 0);
      step(1, 1, 0, 0, 1, 0, 'h40, 0);
      step(1, 1, 0, 0, 1, 0, 'h80, 0);
      step(1, 1, 0, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 1, 0, 0);
      // overflow
      step(1, 1, 1, 0, 0, 0, 'h00, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 0, 'h40, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1, 0, 0);
      // underflow, call+ret priority, reset mid-sequence
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 1, 1, 'h60, 0);
      step(1, 1, 0, 0, 1, 0, 'h60, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0);
      idle(1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
      end

      @(negedge clk);
      @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_seq_ras.md
Name: pc_seq_ras

Overview:
- Parametrised program-counter sequencer: next generation of the 8-bit +4 PC.
- Adds configurable width, step and reset vector, a stall input, absolute jump, signed relative branch, and call/return through an internal return-address stack (RAS) with full/empty/error flags.
- Drives the fetch address of the core; sits between the instruction decoder and the instruction memory.

Parameters:
- AW, 8, PC/address width in bits (4..32).
- STEP, 4, sequential increment in bytes.
- RESET_PC, 0, PC value loaded on reset (AW bits).
- DEPTH, 4, RAS entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  advance enable; 0 = stall, all state held.
- jump  in  1  absolute jump to target.
- branch  in  1  relative branch: PC + offset.
- call  in  1  push PC+STEP, then jump to target.
- ret  in  1  pop RAS into PC.
- target  in  AW  absolute jump/call address.
- offset  in  AW  two's-complement branch offset.
- pc  out  AW  current PC (registered).
- ras_full  out  1  RAS holds DEPTH entries.
- ras_empty  out  1  RAS holds 0 entries.
- ras_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0. Reset overrides en and all commands; RAS contents are don't-care.
- en=0: pc, RAS, count and flags held; commands are ignored (not queued).
- en=1, one command per cycle, priority ret > call > jump > branch > increment:
  - ret, count>0: pc <= top entry; count-1.
  - ret, count=0 (underflow): pc <= pc+STEP; ras_err <= 1; count stays 0.
  - call, count<DEPTH: push pc+STEP; pc <= target; count+1.
  - call, count=DEPTH (overflow): pc <= target; push dropped, stack unchanged; ras_err <= 1.
  - jump: pc <= target.
  - branch: pc <= pc+offset.
  - none asserted: pc <= pc+STEP.
- Lower-priority commands asserted in the same cycle are discarded; only the winner has any effect.
- Arithmetic: all sums modulo 2^AW; wrap-around is silent (0xFC+4 -> 0x00 for AW=8). Pushed return address is also modulo 2^AW.
- Latency: pc reflects the command one cycle after the sampling edge. No combinational path from inputs to outputs.
- Flags are registered from the count after update: ras_full = (count==DEPTH), ras_empty = (count==0).
- ras_err clears only on reset.
- Count needs clog2(DEPTH)+1 bits. The stack is LIFO: pointer-indexed register array, top = entry[count-1].

Decomposition:
- Package pc_seq_pkg:
  - next-PC select enum: SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET.
  - clog2 helper function.
- Sub-module pc_ras: DEPTH x AW LIFO.
  - Inputs: push, pop, din.
  - Outputs: top, full, empty, ovf/udf pulses.
- Top level: priority select, adders, pc register, sticky error.

Test Plan:
- Reset/increment (AW=8, STEP=4, RESET_PC=0x10): rst_n low 2 cycles, then 3 idle cycles -> pc 0x10, 0x14, 0x18, 0x1C; ras_empty=1.
- Stall/wrap: pc=0xF8, en=0 for 2 cycles -> pc holds 0xF8. Then en=1 for 2 cycles -> 0xFC, then 0x00.
- Branch/jump: pc=0x20, branch offset=0xF0 (-16) -> 0x10. Then jump target=0x80 -> 0x80. Then branch+jump together with target=0x40 -> 0x40 (jump wins).
- Nested call/ret: pc=0x00, call 0x40 -> pc=0x40, count 1. Then call 0x80 -> pc=0x80. Then ret -> 0x44. Then ret -> 0x04, ras_empty=1, ras_err=0.
- Overflow (DEPTH=4): 5 consecutive calls to 0x40 -> after the 4th ras_full=1; the 5th sets ras_err=1, pc=0x40. Then 4 rets return 0x44, 0x44, 0x44, 0x04 (last is the first push, from pc 0x00).
- Underflow/priority: with the stack empty, ret -> pc+4 and ras_err=1. Then call+ret in the same cycle -> ret wins, no push. Then reset mid-sequence -> pc=RESET_PC, ras_err=0, count=0.
